// File: rtl/ahb_slave_response_router_if.sv
// Address-phase inputs from the interconnect, slave responses in, master responses out.
// Zero-latency return path; backpressure is the slave hreadyout gated by data-phase ownership.
interface ahb_slave_response_router_if #(
  parameter int NO_OF_MASTERS = 4,
  parameter int NO_OF_SLAVES  = 4,
  parameter int DATA_WIDTH    = 32
);
  localparam int MW = $clog2(NO_OF_MASTERS);

  logic [NO_OF_SLAVES-1:0]               addr_valid_i;
  logic [NO_OF_SLAVES*MW-1:0]            addr_owner_i;
  logic [NO_OF_SLAVES-1:0]               hwrite_i;
  logic [NO_OF_SLAVES*DATA_WIDTH-1:0]    hrdata_s_i;
  logic [NO_OF_SLAVES-1:0]               hreadyout_s_i;
  logic [NO_OF_SLAVES-1:0]               hresp_s_i;
  logic [NO_OF_SLAVES-1:0]               hready_s_o;
  logic [NO_OF_MASTERS*DATA_WIDTH-1:0]   hrdata_m_o;
  logic [NO_OF_MASTERS-1:0]              hready_m_o;
  logic [NO_OF_MASTERS-1:0]              hresp_m_o;
  logic [NO_OF_SLAVES-1:0]               dp_busy_o;
  logic                                  protocol_err_o;
  logic [15:0]                           err_cnt_o;

  // Router side
  modport slave (
    input  addr_valid_i, addr_owner_i, hwrite_i, hrdata_s_i, hreadyout_s_i, hresp_s_i,
    output hready_s_o, hrdata_m_o, hready_m_o, hresp_m_o, dp_busy_o, protocol_err_o, err_cnt_o
  );

  // Interconnect / environment side
  modport master (
    output addr_valid_i, addr_owner_i, hwrite_i, hrdata_s_i, hreadyout_s_i, hresp_s_i,
    input  hready_s_o, hrdata_m_o, hready_m_o, hresp_m_o, dp_busy_o, protocol_err_o, err_cnt_o
  );
endinterface

// File: rtl/ahb_slave_response_router.sv
// Per-slave data-phase owner tracking and response routing back to the owning master.
// Zero added latency (combinational from registered owner); stalls follow the slave's hreadyout.
module ahb_slave_response_router #(
  parameter int NO_OF_MASTERS = 4,
  parameter int NO_OF_SLAVES  = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                          hclk,
  input  logic                          hreset,
  ahb_slave_response_router_if.slave    bus
);
  localparam int MW = $clog2(NO_OF_MASTERS);

  typedef enum logic [1:0] {IDLE, DATA, ERR} state_t;

  state_t                     state_q [NO_OF_SLAVES];
  state_t                     state_d [NO_OF_SLAVES];
  logic [MW-1:0]              owner_q [NO_OF_SLAVES];
  logic [NO_OF_SLAVES-1:0]    wr_q;
  logic [NO_OF_SLAVES-1:0]    hready_s;
  logic [NO_OF_SLAVES-1:0]    accept;
  logic [NO_OF_SLAVES-1:0]    err_done;
  logic [NO_OF_SLAVES-1:0]    fault;
  logic [NO_OF_MASTERS-1:0]   claimed;
  logic                       multi_own;
  logic [NO_OF_MASTERS-1:0]   hready_m;
  logic [NO_OF_MASTERS-1:0]   hresp_m;
  logic [NO_OF_MASTERS*DATA_WIDTH-1:0] hrdata_m;
  logic                       perr_q;
  logic [15:0]                ecnt_q;
  logic [15:0]                ecnt_d;
  logic [16:0]                ecnt_sum;

  always_comb begin
    for (int s = 0; s < NO_OF_SLAVES; s++) begin
      state_d[s]  = state_q[s];
      err_done[s] = 1'b0;
      fault[s]    = 1'b0;
      hready_s[s] = (state_q[s] == IDLE) ? 1'b1 : bus.hreadyout_s_i[s];
      accept[s]   = bus.addr_valid_i[s] && hready_s[s];
      case (state_q[s])
        IDLE: if (accept[s]) state_d[s] = DATA;
        DATA: begin
          case ({bus.hreadyout_s_i[s], bus.hresp_s_i[s]})
            2'b10: state_d[s] = accept[s] ? DATA : IDLE;
            2'b01: state_d[s] = ERR;
            2'b11: begin
              // One-cycle ERROR is illegal but still ends the transfer
              fault[s]   = 1'b1;
              state_d[s] = accept[s] ? DATA : IDLE;
            end
            default: state_d[s] = DATA;
          endcase
        end
        ERR: begin
          if (!bus.hresp_s_i[s]) begin
            fault[s]   = 1'b1;
            state_d[s] = IDLE;
          end else if (bus.hreadyout_s_i[s]) begin
            err_done[s] = 1'b1;
            state_d[s]  = accept[s] ? DATA : IDLE;
          end
        end
        default: state_d[s] = IDLE;
      endcase
    end
  end

  always_comb begin
    ecnt_sum = {1'b0, ecnt_q};
    for (int s = 0; s < NO_OF_SLAVES; s++) begin
      ecnt_sum = ecnt_sum + 17'(err_done[s]);
    end
    ecnt_d = ecnt_sum[16] ? 16'hFFFF : ecnt_sum[15:0];
  end

  // Lowest-indexed slave wins a master claimed twice; the clash is flagged as a fault
  always_comb begin
    claimed   = '0;
    multi_own = 1'b0;
    hready_m  = '1;
    hresp_m   = '0;
    hrdata_m  = '0;
    for (int s = 0; s < NO_OF_SLAVES; s++) begin
      if (state_q[s] != IDLE && int'(owner_q[s]) < NO_OF_MASTERS) begin
        if (claimed[owner_q[s]]) begin
          multi_own = 1'b1;
        end else begin
          claimed[owner_q[s]]  = 1'b1;
          hready_m[owner_q[s]] = bus.hreadyout_s_i[s];
          hresp_m[owner_q[s]]  = bus.hresp_s_i[s];
          hrdata_m[int'(owner_q[s])*DATA_WIDTH +: DATA_WIDTH] =
            wr_q[s] ? '0 : bus.hrdata_s_i[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int s = 0; s < NO_OF_SLAVES; s++) state_q[s] <= IDLE;
    end else begin
      for (int s = 0; s < NO_OF_SLAVES; s++) state_q[s] <= state_d[s];
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int s = 0; s < NO_OF_SLAVES; s++) owner_q[s] <= '0;
      wr_q   <= '0;
      perr_q <= 1'b0;
      ecnt_q <= '0;
    end else begin
      for (int s = 0; s < NO_OF_SLAVES; s++) begin
        if (accept[s]) begin
          owner_q[s] <= bus.addr_owner_i[s*MW +: MW];
          wr_q[s]    <= bus.hwrite_i[s];
        end
      end
      if (|fault || multi_own) perr_q <= 1'b1;
      ecnt_q <= ecnt_d;
    end
  end

  always_comb begin
    for (int s = 0; s < NO_OF_SLAVES; s++) begin
      bus.dp_busy_o[s] = (state_q[s] != IDLE);
    end
  end

  assign bus.hready_s_o     = hready_s;
  assign bus.hready_m_o     = hready_m;
  assign bus.hresp_m_o      = hresp_m;
  assign bus.hrdata_m_o     = hrdata_m;
  assign bus.protocol_err_o = perr_q;
  assign bus.err_cnt_o      = ecnt_q;

endmodule

// File: tb/tb_ahb_slave_response_router.sv
// Directed vector table plus randomized traffic against a transaction-level model.
module tb_ahb_slave_response_router;
  localparam int NM = 4;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int MW = 2;

  logic hclk = 1'b0;
  logic hreset;

  always #5 hclk = ~hclk;

  ahb_slave_response_router_if #(.NO_OF_MASTERS(NM), .NO_OF_SLAVES(NS), .DATA_WIDTH(DW)) bus ();

  ahb_slave_response_router #(.NO_OF_MASTERS(NM), .NO_OF_SLAVES(NS), .DATA_WIDTH(DW)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [7:0]  own;
    logic [3:0]  wr;
    logic [31:0] base;
    logic [3:0]  hro;
    logic [3:0]  hrs;
    logic [3:0]  e_hrm;
    logic [3:0]  e_hresp;
    logic [3:0]  e_dp;
    logic [3:0]  e_hrs;
    logic        e_perr;
    logic [15:0] e_ecnt;
    int          chk_m;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic [3:0] vld, input logic [7:0] own,
                     input logic [3:0] wr, input logic [31:0] base, input logic [3:0] hro,
                     input logic [3:0] hrs, input logic [3:0] e_hrm, input logic [3:0] e_hresp,
                     input logic [3:0] e_dp, input logic [3:0] e_hrs, input logic e_perr,
                     input logic [15:0] e_ecnt, input int chk_m, input logic [31:0] e_rd);
    vec_t v;
    v.rst = rst; v.vld = vld; v.own = own; v.wr = wr; v.base = base; v.hro = hro; v.hrs = hrs;
    v.e_hrm = e_hrm; v.e_hresp = e_hresp; v.e_dp = e_dp; v.e_hrs = e_hrs;
    v.e_perr = e_perr; v.e_ecnt = e_ecnt; v.chk_m = chk_m; v.e_rd = e_rd;
    tv.push_back(v);
  endtask

  // Reference model: per slave, the master owning the pending data phase (-1 = none)
  int   m_own [NS];
  bit   m_wr  [NS];
  bit   m_err [NS];
  bit   m_perr;
  int   m_ecnt;
  logic [NM-1:0]    x_hrm, x_hresp;
  logic [NM*DW-1:0] x_rd;
  logic [NS-1:0]    x_dp, x_hrs;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin m_own[s] = -1; m_wr[s] = 0; m_err[s] = 0; end
    m_perr = 0;
    m_ecnt = 0;
  endtask

  task automatic model_eval();
    x_hrm = '1; x_hresp = '0; x_rd = '0;
    for (int s = 0; s < NS; s++) begin
      x_dp[s]  = (m_own[s] >= 0);
      x_hrs[s] = (m_own[s] < 0) ? 1'b1 : bus.hreadyout_s_i[s];
    end
    for (int m = 0; m < NM; m++) begin
      bit found = 0;
      for (int s = 0; s < NS; s++) begin
        if (!found && m_own[s] == m) begin
          found = 1;
          x_hrm[m]   = bus.hreadyout_s_i[s];
          x_hresp[m] = bus.hresp_s_i[s];
          x_rd[m*DW +: DW] = m_wr[s] ? 32'h0 : bus.hrdata_s_i[s*DW +: DW];
        end
      end
    end
  endtask

  task automatic finish_or_reload(input int s, input bit acc);
    m_err[s] = 0;
    if (acc) begin
      m_own[s] = int'(bus.addr_owner_i[s*MW +: MW]);
      m_wr[s]  = bus.hwrite_i[s];
    end else begin
      m_own[s] = -1;
    end
  endtask

  task automatic model_step();
    for (int a = 0; a < NS; a++)
      for (int b = a + 1; b < NS; b++)
        if (m_own[a] >= 0 && m_own[a] == m_own[b]) m_perr = 1;
    for (int s = 0; s < NS; s++) begin
      bit acc = bus.addr_valid_i[s] && x_hrs[s];
      bit ro  = bus.hreadyout_s_i[s];
      bit rs  = bus.hresp_s_i[s];
      if (m_own[s] < 0) begin
        if (acc) finish_or_reload(s, 1'b1);
      end else if (!m_err[s]) begin
        if (ro && rs) m_perr = 1;
        if (ro) finish_or_reload(s, acc);
        else if (rs) m_err[s] = 1;
      end else begin
        if (!rs) begin m_perr = 1; m_own[s] = -1; m_err[s] = 0; end
        else if (ro) begin
          if (m_ecnt < 65535) m_ecnt++;
          finish_or_reload(s, acc);
        end
      end
    end
  endtask

  function automatic logic [255:0] dut_vec();
    return {95'b0, bus.hready_m_o, bus.hresp_m_o, bus.dp_busy_o, bus.hready_s_o,
            bus.protocol_err_o, bus.err_cnt_o, bus.hrdata_m_o};
  endfunction

  initial begin
    hreset = 1'b1;
    bus.addr_valid_i = '0; bus.addr_owner_i = '0; bus.hwrite_i = '0;
    bus.hrdata_s_i = '0; bus.hreadyout_s_i = '1; bus.hresp_s_i = '0;

    //   rst vld    own    wr     base          hro    hrs    hrm    hresp  dp     hrs_s  perr ecnt m rd
    add(1, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 0, 32'h0);
    add(0, 4'h1, 8'h02, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 2, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'hDEADBEEF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h1, 4'hF, 0, 0, 2, 32'hDEADBEEF);
    add(0, 4'h0, 8'h00, 4'h0, 32'hDEADBEEF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 2, 32'h0);
    add(0, 4'h8, 8'h40, 4'h8, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 1, 32'h0);
    add(0, 4'h8, 8'h40, 4'h8, 32'h12345678, 4'h7, 4'h0, 4'hD, 4'h0, 4'h8, 4'h7, 0, 0, 1, 32'h0);
    add(0, 4'h8, 8'h40, 4'h8, 32'h12345678, 4'h7, 4'h0, 4'hD, 4'h0, 4'h8, 4'h7, 0, 0, 1, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h12345678, 4'hF, 4'h0, 4'hF, 4'h0, 4'h8, 4'hF, 0, 0, 1, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 1, 32'h0);
    add(0, 4'h4, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 0, 32'h0);
    add(0, 4'h4, 8'h30, 4'h0, 32'hCAFE0000, 4'hF, 4'h0, 4'hF, 4'h0, 4'h4, 4'hF, 0, 0, 0, 32'hCAFE0002);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0BAD0000, 4'hF, 4'h0, 4'hF, 4'h0, 4'h4, 4'hF, 0, 0, 3, 32'h0BAD0002);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 3, 32'h0);
    add(0, 4'h2, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 0, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h100,      4'hD, 4'h2, 4'hE, 4'h1, 4'h2, 4'hD, 0, 0, 0, 32'h101);
    add(0, 4'h0, 8'h00, 4'h0, 32'h100,      4'hF, 4'h2, 4'hF, 4'h1, 4'h2, 4'hF, 0, 0, 0, 32'h101);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 1, 0, 32'h0);
    add(0, 4'h1, 8'h03, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 1, 3, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0A0,      4'hF, 4'h1, 4'hF, 4'h8, 4'h1, 4'hF, 0, 1, 3, 32'h0A0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1, 1, 3, 32'h0);
    add(1, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 3, 32'h0);
    add(0, 4'h2, 8'h08, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 2, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hD, 4'h2, 4'hB, 4'h4, 4'h2, 4'hD, 0, 0, 2, 32'h1);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h2, 4'hF, 0, 0, 2, 32'h1);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1, 0, 2, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1, 0, 2, 32'h0);
    add(0, 4'h2, 8'h04, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1, 0, 1, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hD, 4'h0, 4'hD, 4'h0, 4'h2, 4'hD, 1, 0, 1, 32'h1);
    add(1, 4'h0, 8'h00, 4'h0, 32'h0,        4'hD, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 1, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hD, 4'h2, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 1, 32'h0);
    add(0, 4'h3, 8'h05, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 1, 32'h0);
    add(0, 4'h0, 8'h00, 4'h0, 32'h500,      4'hF, 4'h0, 4'hF, 4'h0, 4'h3, 4'hF, 0, 0, 1, 32'h500);
    add(0, 4'h0, 8'h00, 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1, 0, 1, 32'h0);

    foreach (tv[i]) begin
      logic [255:0] act, exp;
      hreset = tv[i].rst;
      bus.addr_valid_i = tv[i].vld; bus.addr_owner_i = tv[i].own; bus.hwrite_i = tv[i].wr;
      bus.hreadyout_s_i = tv[i].hro; bus.hresp_s_i = tv[i].hrs;
      for (int s = 0; s < NS; s++) bus.hrdata_s_i[s*DW +: DW] = tv[i].base + 32'(s);
      @(negedge hclk);
      act = {151'b0, bus.hready_m_o, bus.hresp_m_o, bus.dp_busy_o, bus.hready_s_o,
             bus.protocol_err_o, bus.err_cnt_o, bus.hrdata_m_o[tv[i].chk_m*DW +: DW]};
      exp = {151'b0, tv[i].e_hrm, tv[i].e_hresp, tv[i].e_dp, tv[i].e_hrs,
             tv[i].e_perr, tv[i].e_ecnt, tv[i].e_rd};
      check($sformatf("vec%0d", i), act, exp);
      @(posedge hclk);
      #1;
    end

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      hreset = (c == 0) || ($urandom_range(0, 99) == 0);
      bus.addr_valid_i = 4'($urandom);
      bus.addr_owner_i = 8'($urandom);
      bus.hwrite_i     = 4'($urandom);
      for (int s = 0; s < NS; s++) begin
        bus.hrdata_s_i[s*DW +: DW] = $urandom;
        bus.hreadyout_s_i[s] = ($urandom_range(0, 3) != 0);
        bus.hresp_s_i[s]     = ($urandom_range(0, 5) == 0);
      end
      if (hreset) model_reset();
      model_eval();
      @(negedge hclk);
      check($sformatf("rand%0d", c), dut_vec(),
            {95'b0, x_hrm, x_hresp, x_dp, x_hrs, m_perr, 16'(m_ecnt), x_rd});
      if (!hreset) model_step();
      @(posedge hclk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ahb_slave_response_router.md
Name: ahb_slave_response_router

Overview:
- Per-slave data-phase tracker and response return path, directly downstream of the AHB interconnect's arbitration/address mux.
- Records which master owns each slave's outstanding data phase.
- Routes each slave's hrdata/hreadyout/hresp back to that master, gates hready to the slave, and flags protocol faults.
- Gives the interconnect the data-phase ownership its arbiter otherwise lacks.

Parameters:
- NO_OF_MASTERS, 4, number of AHB masters (>=2)
- NO_OF_SLAVES, 4, number of AHB slaves (>=1)
- DATA_WIDTH, 32, hrdata width
- MW, $clog2(NO_OF_MASTERS), master-id width (derived, not overridable)

Ports:
- hclk  in  1  bus clock, all state on rising edge
- hreset  in  1  asynchronous, active-high reset
- addr_valid_i  in  NO_OF_SLAVES  slave s sees a NONSEQ/SEQ address phase with hselx=1 this cycle
- addr_owner_i  in  NO_OF_SLAVES*MW  granted master id for slave s's address phase
- hwrite_i  in  NO_OF_SLAVES  hwrite of that address phase
- hrdata_s_i  in  NO_OF_SLAVES*DATA_WIDTH  slave read data
- hreadyout_s_i  in  NO_OF_SLAVES  slave hreadyout
- hresp_s_i  in  NO_OF_SLAVES  slave hresp (1=ERROR)
- hready_s_o  out  NO_OF_SLAVES  hready driven to slave s
- hrdata_m_o  out  NO_OF_MASTERS*DATA_WIDTH  read data to master m
- hready_m_o  out  NO_OF_MASTERS  hready to master m
- hresp_m_o  out  NO_OF_MASTERS  hresp to master m
- dp_busy_o  out  NO_OF_SLAVES  slave s has an outstanding data phase
- protocol_err_o  out  1  sticky protocol-fault flag
- err_cnt_o  out  16  saturating count of completed ERROR responses

Behaviour:
- Reset (hreset=1, async):
  - All slave FSMs go to IDLE; owners cleared to 0; registered hwrite cleared.
  - protocol_err_o=0, err_cnt_o=0.
  - Resulting outputs: hready_m_o all 1, hresp_m_o all 0, hrdata_m_o all 0, hready_s_o all 1, dp_busy_o all 0.
- Per-slave FSM, states IDLE, DATA, ERR:
  - hready_s_o[s] = 1 in IDLE, otherwise hreadyout_s_i[s].
  - Address accept: addr_valid_i[s] && hready_s_o[s]. On accept, owner[s] <= addr_owner_i[s], wr[s] <= hwrite_i[s]. Data phase starts in the next cycle.
  - IDLE: accept -> DATA; otherwise stay.
  - DATA:
    - hreadyout=1, hresp=0: transfer done. Accept -> DATA (back-to-back, owner reloaded); else -> IDLE.
    - hreadyout=0, hresp=1: -> ERR.
    - hreadyout=0, hresp=0: wait state, stay. addr_valid_i is ignored and the interconnect must hold it.
    - hreadyout=1, hresp=1: single-cycle ERROR, illegal. Set protocol_err_o, treat as completion.
  - ERR:
    - hreadyout=1, hresp=1: error done, err_cnt_o += 1 (saturates at 16'hFFFF). Accept -> DATA; else -> IDLE.
    - hresp=0: set protocol_err_o, -> IDLE.
    - hreadyout=0, hresp=1: stay.
  - dp_busy_o[s] = (state != IDLE).
- Return path, combinational from registered owner, zero added latency:
  - Master m is owned by slave s when state[s] != IDLE and owner[s]==m.
  - hready_m_o[m] = hreadyout_s_i[s]; hresp_m_o[m] = hresp_s_i[s].
  - hrdata_m_o[m] = hrdata_s_i[s] when wr[s]=0, else 0.
  - Unowned master: hready 1, hresp 0, hrdata 0.
  - Two slaves owning the same master: lowest slave index wins, protocol_err_o set on the next edge.
- protocol_err_o clears only on reset.
- Reset mid-transfer aborts all data phases immediately. No response is forwarded after reset deasserts until a new accept.

Test Plan:
- Reset with slave 1 in DATA -> dp_busy_o=0, hready_m_o=4'b1111, hresp_m_o=0, err_cnt_o=0 in the same cycle.
- Read, owner=2 on slave 0; slave returns hreadyout=1, hrdata=32'hDEADBEEF one cycle later -> hrdata_m_o[2]=DEADBEEF, hready_m_o[2]=1, slave 0 back to IDLE.
- Write to slave 3 from master 1 with 2 wait states -> hready_m_o[1]=0 for 2 cycles then 1; hrdata_m_o[1]=0; addr_valid_i held during waits is not accepted.
- Back-to-back accepts on slave 2 (owners 0 then 3) with zero waits -> dp_busy_o[2] stays 1; response cycle 1 routed to master 0, cycle 2 to master 3.
- Two-cycle ERROR (hresp=1/hreadyout=0, then hresp=1/hreadyout=1) on slave 1 owned by master 0 -> hresp_m_o[0]=1 both cycles, err_cnt_o increments by 1, protocol_err_o=0.
- Single-cycle ERROR (hresp=1, hreadyout=1), and separately ERR followed by hresp=0 -> protocol_err_o=1 and held until reset.
